// File: rtl/segway_pkg.sv
// Shared types and constants for the segway balance/steering blocks.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEER
    } steer_state_t;

    localparam int LD_W       = 12;
    localparam int TMR_W      = 26;
    localparam int FAST_TMR_W = 15;
    localparam int NXT_PERIOD = 4096;

    localparam logic [LD_W-1:0] MIN_RIDER_WT  = 12'h200;
    localparam logic [LD_W-1:0] WT_HYSTERESIS = 12'h40;

endpackage

// File: rtl/steer_en_sm_if.sv
// Load-cell readings in, conversion pacing and rider status out.
interface steer_en_sm_if;
    import segway_pkg::*;

    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            nxt;
    logic            en_steer;
    logic            rider_off;

    modport master (
        output lft_ld,
        output rght_ld,
        input  nxt,
        input  en_steer,
        input  rider_off
    );

    modport slave (
        input  lft_ld,
        input  rght_ld,
        output nxt,
        output en_steer,
        output rider_off
    );

endinterface

// File: rtl/a2d_pacer.sv
// Free-running period counter issuing a one-cycle nxt request per period.
module a2d_pacer
    import segway_pkg::*;
#(
    parameter int PERIOD = NXT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    output logic nxt
);

    localparam int            CW   = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            nxt <= 1'b0;
        end else begin
            nxt <= (cnt == LAST);
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/steer_en_sm.sv
// Rider presence/balance state machine and A2D pacing.
// STEER_FAST_SIM_EN shortens the balance timer decode to 15 bits.
module steer_en_sm
    import segway_pkg::*;
(
    input logic          clk,
    input logic          rst,
    steer_en_sm_if.slave bus
);

    localparam logic [LD_W:0] SUM_HI = {1'b0, MIN_RIDER_WT + WT_HYSTERESIS};
    localparam logic [LD_W:0] SUM_LO = {1'b0, MIN_RIDER_WT - WT_HYSTERESIS};

    logic [LD_W:0]    sum;
    logic [LD_W-1:0]  diff;
    logic [LD_W+4:0]  sum15;
    logic             sum_gt_min;
    logic             sum_lt_min;
    logic             diff_gt_1_4;
    logic             diff_gt_15_16;
    logic [TMR_W-1:0] tmr;
    logic             tmr_full;
    logic             clr_tmr;
    logic             en_q;
    logic             off_q;
    steer_state_t     st;
    steer_state_t     nxt_st;

    assign sum  = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    assign diff = (bus.lft_ld >= bus.rght_ld) ? bus.lft_ld - bus.rght_ld
                                              : bus.rght_ld - bus.lft_ld;

    assign sum_gt_min = sum > SUM_HI;
    assign sum_lt_min = sum < SUM_LO;

    // 15*sum as (sum<<4)-sum, widened so the shift cannot overflow
    assign sum15 = ({4'b0, sum} << 4) - {4'b0, sum};

    assign diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    assign diff_gt_15_16 = {1'b0, diff} > sum15[LD_W+4:4];

`ifdef STEER_FAST_SIM_EN
    assign tmr_full = &tmr[FAST_TMR_W-1:0];
`else
    assign tmr_full = &tmr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr <= '0;
        else if (clr_tmr) tmr <= '0;
        else tmr <= tmr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            en_q  <= 1'b0;
            off_q <= 1'b1;
        end else begin
            st    <= nxt_st;
            en_q  <= (nxt_st == STEER);
            off_q <= (nxt_st == IDLE);
        end
    end

    // Low load always drops the rider, whatever the balance
    always_comb begin
        nxt_st  = st;
        clr_tmr = 1'b0;
        unique case (st)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt_st  = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) nxt_st = IDLE;
                else if (diff_gt_1_4) clr_tmr = 1'b1;
                else if (tmr_full) nxt_st = STEER;
            end
            STEER: begin
                if (sum_lt_min) nxt_st = IDLE;
                else if (diff_gt_15_16) begin
                    nxt_st  = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: nxt_st = IDLE;
        endcase
    end

    assign bus.en_steer  = en_q;
    assign bus.rider_off = off_q;

    a2d_pacer #(
        .PERIOD(NXT_PERIOD)
    ) u_pacer (
        .clk(clk),
        .rst(rst),
        .nxt(bus.nxt)
    );

endmodule

// File: tb/tb_steer_en_sm.sv
// Scoreboard bench for steer_en_sm: rider state, balance timer, nxt pacing.
module tb_steer_en_sm;
    import segway_pkg::*;

    localparam logic [TMR_W-1:0] FULL = '1;

    typedef struct {
        string      tag;
        logic [1:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ecnt;
    exp_t sb[$];
    int   nq[$];

    steer_en_sm_if bus ();

    steer_en_sm dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #10 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // nxt pulses are matched against the cycle numbers queued at reset release
    always @(negedge clk) begin
        int e;
        if (!rst && bus.nxt) begin
            if (nq.size() == 0) begin
                check("nxt_extra", 32'(ecnt), 32'd0);
            end else begin
                e = nq.pop_front();
                check("nxt_time", 32'(ecnt), 32'(e));
                nq.push_back(e + NXT_PERIOD);
            end
        end
    end

    task automatic step(input string tag, input logic [11:0] l,
                        input logic [11:0] r, input logic en,
                        input logic off);
        exp_t x;
        @(negedge clk);
        bus.lft_ld  = l;
        bus.rght_ld = r;
        x.tag = tag;
        x.v   = {en, off};
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check(x.tag, {30'b0, bus.en_steer, bus.rider_off}, {30'b0, x.v});
    endtask

    task automatic preload(input int back);
        @(negedge clk);
        force dut.tmr = FULL - TMR_W'(back);
        @(negedge clk);
        release dut.tmr;
    endtask

    task automatic reach_steer(input string tag, input logic [11:0] l,
                               input logic [11:0] r);
        bit seen;
        seen = 1'b0;
        preload(30);
        repeat (25) step({tag, "_pre"}, l, r, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.en_steer) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'b0, seen}, 32'd1);
        check({tag, "_off"}, {31'b0, bus.rider_off}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lft_ld  = '0;
        bus.rght_ld = '0;
        repeat (3) @(negedge clk);
        check("rst_en", {31'b0, bus.en_steer}, 32'd0);
        check("rst_off", {31'b0, bus.rider_off}, 32'd1);
        check("rst_nxt", {31'b0, bus.nxt}, 32'd0);
        nq.push_back(NXT_PERIOD);
        rst = 1'b0;

        repeat (5) step("idle_zero", 12'h000, 12'h000, 1'b0, 1'b1);
        repeat (3) step("idle_band", 12'h0F0, 12'h0F0, 1'b0, 1'b1);
        step("idle_edge", 12'h120, 12'h120, 1'b0, 1'b1);
        step("enter_wait", 12'h121, 12'h120, 1'b0, 1'b0);
        repeat (5) step("wait_bal", 12'h200, 12'h200, 1'b0, 1'b0);

        preload(40);
        repeat (20) step("wait_pre", 12'h200, 12'h200, 1'b0, 1'b0);
        step("wait_unbal", 12'h300, 12'h100, 1'b0, 1'b0);
        repeat (60) step("wait_restart", 12'h200, 12'h200, 1'b0, 1'b0);

        reach_steer("steer_q_edge", 12'h280, 12'h180);
        repeat (3) step("steer_hold", 12'h3C0, 12'h040, 1'b1, 1'b0);
        step("steer_edge", 12'h3E0, 12'h020, 1'b1, 1'b0);
        step("steer_drop", 12'h400, 12'h000, 1'b0, 1'b0);
        step("wait_lt_wins", 12'h1A0, 12'h000, 1'b0, 1'b1);

        step("rewait", 12'h200, 12'h200, 1'b0, 1'b0);
        reach_steer("steer_2", 12'h200, 12'h200);
        repeat (3) step("steer_band_hi", 12'h0F0, 12'h0F0, 1'b1, 1'b0);
        repeat (3) step("steer_band_lo", 12'h0E0, 12'h0E0, 1'b1, 1'b0);
        step("steer_off", 12'h0D0, 12'h0D0, 1'b0, 1'b1);

        step("rewait2", 12'h200, 12'h200, 1'b0, 1'b0);
        reach_steer("steer_3", 12'h200, 12'h200);

        for (int i = 0; i < 20000 && ecnt != 3 * NXT_PERIOD - 96; i++)
            @(negedge clk);
        check("pacer_pos", 32'(ecnt), 32'(3 * NXT_PERIOD - 96));
        check("pre_rst_en", {31'b0, bus.en_steer}, 32'd1);

        rst = 1'b1;
        #1;
        check("mid_rst_en", {31'b0, bus.en_steer}, 32'd0);
        check("mid_rst_off", {31'b0, bus.rider_off}, 32'd1);
        check("mid_rst_nxt", {31'b0, bus.nxt}, 32'd0);
        repeat (3) @(negedge clk);
        nq.delete();
        nq.push_back(NXT_PERIOD);
        bus.lft_ld  = '0;
        bus.rght_ld = '0;
        rst = 1'b0;

        repeat (NXT_PERIOD + 4) step("post_rst", 12'h000, 12'h000, 1'b0, 1'b1);
        check("nxt_pending", (nq.size() == 1) ? 32'(nq[0]) : 32'hFFFF_FFFF,
              32'(2 * NXT_PERIOD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
